// File: rtl/div_seq.sv
// div_seq: sequential radix-2 restoring divider, signed or unsigned.
//
// One quotient bit is produced per clock, so a division with a non-zero
// divisor always takes WIDTH+2 edges from the accepting edge to done.
// A zero divisor skips the iteration and completes on the next edge.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   start        request a division (sampled only while busy=0)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   dividend     numerator, latched with start
//   divisor      denominator, latched with start
//   busy         division in progress
//   done         one-cycle pulse, results valid
//   div_zero     last completed operation had a zero divisor
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] quo_acc;   // holds the dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvs_mag;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             zero_f;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] maxpos;

    assign sa    = signed_mode & dividend[WIDTH-1];
    assign sb    = signed_mode & divisor[WIDTH-1];
    assign mag_a = sa ? -dividend : dividend;
    assign mag_b = sb ? -divisor  : divisor;

    // Trial subtraction: the shifted partial remainder needs WIDTH+1 bits,
    // but when it is >= the divisor the difference always fits in WIDTH bits,
    // so the subtraction itself can be done modulo 2^WIDTH.
    assign shifted = {rem_acc, quo_acc[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, dvs_mag});
    assign rem_sub = shifted[WIDTH-1:0] - dvs_mag;

    assign maxpos = {1'b0, {(WIDTH-1){1'b1}}};
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (divisor == '0) ? FIX : CALC;
            CALC:    if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            quo_acc   <= '0;
            rem_acc   <= '0;
            dvs_mag   <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_f    <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_acc <= mag_a;
                        rem_acc <= '0;
                        dvs_mag <= mag_b;
                        cnt     <= CW'(WIDTH);
                        sign_q  <= sa ^ sb;
                        sign_r  <= sa;
                        zero_f  <= (divisor == '0);
                    end
                end
                CALC: begin
                    rem_acc <= ge ? rem_sub : shifted[WIDTH-1:0];
                    quo_acc <= {quo_acc[WIDTH-2:0], ge};
                    cnt     <= cnt - CW'(1);
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= zero_f;
                    if (zero_f) begin
                        quotient  <= maxpos;
                        remainder <= maxpos;
                    end else begin
                        // MIN / -1 needs no special case: |MIN| reinterpreted
                        // unsigned divided by 1 is MIN, and sign_q is 0.
                        quotient  <= sign_q ? -quo_acc : quo_acc;
                        remainder <= sign_r ? -rem_acc : rem_acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, dz32;
    logic [31:0] q32, r32;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  q8, r8;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;
    int n_done8 = 0;

    always #5 clock = ~clock;

    div_seq #(.WIDTH(32)) u32 (
        .clock(clock), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .div_zero(dz32), .quotient(q32), .remainder(r32)
    );

    div_seq #(.WIDTH(8)) u8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .div_zero(dz8), .quotient(q8), .remainder(r8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference division from plain integer arithmetic.
    function automatic void ref_div(input int w, input logic sm,
                                    input logic [63:0] a_in, input logic [63:0] b_in,
                                    output logic [63:0] q, output logic [63:0] r,
                                    output logic dz);
        logic [63:0] mask, a, b;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        dz = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            q  = mask >> 1;
            r  = mask >> 1;
        end else if (sm) begin
            sa = longint'(a) - (a[w-1] ? longint'(64'd1 << w) : 64'sd0);
            sb = longint'(b) - (b[w-1] ? longint'(64'd1 << w) : 64'sd0);
            q  = 64'(sa / sb) & mask;
            r  = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Transaction-level model: index 0 is the 32-bit instance, 1 the 8-bit one.
    int          m_left[2] = '{0, 0};
    logic [63:0] m_q[2]  = '{0, 0}, m_r[2]  = '{0, 0};
    logic [63:0] m_pq[2] = '{0, 0}, m_pr[2] = '{0, 0};
    logic        m_dz[2] = '{0, 0}, m_pdz[2] = '{0, 0}, m_done[2] = '{0, 0};

    task automatic mstep(input int i, input int w, input logic st, input logic sm,
                         input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        logic dz;
        if (!reset_n) begin
            m_left[i] = 0; m_done[i] = 0;
            m_q[i] = 0; m_r[i] = 0; m_dz[i] = 0;
        end else begin
            m_done[i] = 0;
            if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_q[i] = m_pq[i]; m_r[i] = m_pr[i]; m_dz[i] = m_pdz[i];
                    m_done[i] = 1;
                end
            end else if (st) begin
                ref_div(w, sm, a, b, q, r, dz);
                m_pq[i] = q; m_pr[i] = r; m_pdz[i] = dz;
                m_left[i] = dz ? 1 : w + 1;
            end
        end
    endtask

    always @(posedge clock) begin
        mstep(0, 32, start32, sm32, {32'b0, a32}, {32'b0, b32});
        mstep(1, 8,  start8,  sm8,  {56'b0, a8},  {56'b0, b8});
    end

    always @(negedge clock) begin
        if (run) begin
            chk("busy32", {63'b0, busy32}, {63'b0, m_left[0] > 0});
            chk("done32", {63'b0, done32}, {63'b0, m_done[0]});
            chk("dz32",   {63'b0, dz32},   {63'b0, m_dz[0]});
            chk("q32",    {32'b0, q32},    m_q[0]);
            chk("r32",    {32'b0, r32},    m_r[0]);
            chk("busy8",  {63'b0, busy8},  {63'b0, m_left[1] > 0});
            chk("done8",  {63'b0, done8},  {63'b0, m_done[1]});
            chk("dz8",    {63'b0, dz8},    {63'b0, m_dz[1]});
            chk("q8",     {56'b0, q8},     m_q[1]);
            chk("r8",     {56'b0, r8},     m_r[1]);
            if (done8) n_done8++;
        end
    end

    // Directed 32-bit op with literal expectations; returns at the negedge
    // where done is seen so the next call starts in the done cycle.
    task automatic op32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int n;
        start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
        @(negedge clock);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; sm32 = $urandom_range(0, 1);
        n = 1;
        while (!done32 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("lat32", 64'(n), edz ? 64'd2 : 64'd34);
        chk("lit_q32", {32'b0, q32}, {32'b0, eq});
        chk("lit_r32", {32'b0, r32}, {32'b0, er});
        chk("lit_dz32", {63'b0, dz32}, {63'b0, edz});
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'hFF;
            3: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_q32", {32'b0, q32}, 64'd0);
        chk("rst_r32", {32'b0, r32}, 64'd0);
        chk("rst_busy32", {63'b0, busy32}, 64'd0);
        chk("rst_done8", {63'b0, done8}, 64'd0);
        reset_n = 1'b1;
        run = 1'b1;
        @(negedge clock);

        op32(1'b1, 32'd7, 32'd3, 32'd2, 32'd1, 1'b0);
        op32(1'b1, 32'd7, -32'sd3, -32'sd2, 32'd1, 1'b0);
        op32(1'b1, -32'sd7, 32'd3, -32'sd2, -32'sd1, 1'b0);
        op32(1'b1, -32'sd7, -32'sd3, 32'd2, -32'sd1, 1'b0);
        op32(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0);
        op32(1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b0);
        op32(1'b1, 32'd5, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
        op32(1'b1, 32'd10, 32'd5, 32'd2, 32'd0, 1'b0);
        op32(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        op32(1'b1, 32'd3, 32'd7, 32'd0, 32'd3, 1'b0);

        // Reset ten cycles into an operation abandons it.
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'd100; b32 = 32'd7;
        @(negedge clock);
        start32 = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_q32", {32'b0, q32}, 64'd0);
        chk("midrst_r32", {32'b0, r32}, 64'd0);
        chk("midrst_busy32", {63'b0, busy32}, 64'd0);
        chk("midrst_done32", {63'b0, done32}, 64'd0);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        op32(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(negedge clock);

        // Random traffic on both instances: start held or toggled freely,
        // including while busy and in done cycles, with occasional resets.
        for (int c = 0; c < 40000; c++) begin
            start8  = ($urandom_range(0, 7) < 5);
            sm8     = $urandom_range(0, 1);
            a8      = pick8();
            b8      = pick8();
            start32 = ($urandom_range(0, 7) < 5);
            sm32    = $urandom_range(0, 1);
            a32     = pick32();
            b32     = pick32();
            reset_n = ($urandom_range(0, 2999) != 0);
            @(negedge clock);
        end
        start8 = 1'b0; start32 = 1'b0; reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("done8_count_ok", {63'b0, n_done8 > 1000}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
